// File: rtl/csr_mem_pkg.sv
// -----------------------------------------------------------------------------
// csr_mem_pkg
// Shared definitions for the machine-timer / software-interrupt CSR block:
//   - DATA_SIZE     : bus width, 64 when RV64I is defined, 32 otherwise
//   - ADDR_*        : register select codes decoded from addr[1:0]
//   - tick_cnt_width: width of the prescaler counter for a given ClockCycles
//   - select_word / merge_word: map a 64-bit register onto the bus width
// -----------------------------------------------------------------------------
package csr_mem_pkg;

`ifdef RV64I
  localparam int DATA_SIZE = 64;
`else
  localparam int DATA_SIZE = 32;
`endif

  localparam logic [1:0] ADDR_MSIP     = 2'b00;
  localparam logic [1:0] ADDR_RSVD     = 2'b01;
  localparam logic [1:0] ADDR_MTIME    = 2'b10;
  localparam logic [1:0] ADDR_MTIMECMP = 2'b11;

  // A single-cycle prescaler still needs a 1-bit counter to exist.
  function automatic int tick_cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

  // Read view of a 64-bit register: whole word on a 64-bit bus, otherwise
  // the half chosen by hi (zero-extended so callers can stay 64 bits wide).
  function automatic logic [63:0] select_word(input logic [63:0] value,
                                              input logic        hi,
                                              input int          data_size);
    if (data_size == 64)
      return value;
    else if (hi)
      return {32'h0, value[63:32]};
    else
      return {32'h0, value[31:0]};
  endfunction

  // Write view: replace the whole word, or only the addressed half.
  function automatic logic [63:0] merge_word(input logic [63:0] old_value,
                                             input logic [63:0] wdata,
                                             input logic        hi,
                                             input int          data_size);
    logic [63:0] result;
    result = old_value;
    if (data_size == 64)
      result = wdata;
    else if (hi)
      result[63:32] = wdata[31:0];
    else
      result[31:0] = wdata[31:0];
    return result;
  endfunction

endpackage

// File: rtl/csr_mem_if.sv
// -----------------------------------------------------------------------------
// csr_mem_if
// Register-access bus of csr_mem.
//   rd_en, wr_en : read / write request (master -> slave)
//   addr[2:0]    : register select; addr[2] picks the upper half on 32-bit
//   wr_data      : write data (DataSize bits)
//   rd_data      : combinational read data (slave -> master)
//   busy         : stall indication, always 0 for this slave
// -----------------------------------------------------------------------------
interface csr_mem_if
  import csr_mem_pkg::*;
#(
  parameter int DataSize = DATA_SIZE
);

  logic                rd_en;
  logic                wr_en;
  logic [2:0]          addr;
  logic [DataSize-1:0] wr_data;
  logic [DataSize-1:0] rd_data;
  logic                busy;

  modport master (
    output rd_en, wr_en, addr, wr_data,
    input  rd_data, busy
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data,
    output rd_data, busy
  );

endinterface

// File: rtl/csr_mem_sync_parallel_counter.sv
// -----------------------------------------------------------------------------
// sync_parallel_counter
// Synchronous up/down counter with parallel load.
//   clock      : rising-edge clock
//   reset      : synchronous active-high, returns value to init_value
//   load       : load load_value (has priority over counting)
//   load_value : parallel load data
//   inc_enable : count up
//   dec_enable : count down (inc and dec together hold the value)
//   value      : current count
// -----------------------------------------------------------------------------
module sync_parallel_counter #(
  parameter int              size       = 7,
  parameter logic [size-1:0] init_value = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [size-1:0] load_value,
  input  logic            inc_enable,
  input  logic            dec_enable,
  output logic [size-1:0] value
);

  // Reset beats load, load beats counting; opposing enables cancel out.
  always_ff @(posedge clock) begin
    if (reset)
      value <= init_value;
    else if (load)
      value <= load_value;
    else if (inc_enable && !dec_enable)
      value <= value + size'(1);
    else if (dec_enable && !inc_enable)
      value <= value - size'(1);
  end

endmodule

// File: rtl/csr_mem.sv
// -----------------------------------------------------------------------------
// csr_mem
// Machine timer and software-interrupt CSRs (msip, mtime, mtimecmp).
//   clock, reset : single clock, synchronous active-high reset
//   bus          : csr_mem_if slave (rd_en, wr_en, addr, wr_data, rd_data, busy)
//   msip         : software interrupt register (DataSize bits)
//   mtime        : 64-bit timer, +1 every ClockCycles rising edges
//   mtimecmp     : 64-bit timer compare value
// Accesses always complete in one cycle; rd_data is a pure mux of addr.
// -----------------------------------------------------------------------------
module csr_mem
  import csr_mem_pkg::*;
#(
  parameter int ClockCycles = 100,
  parameter int DataSize    = DATA_SIZE
) (
  input  logic                clock,
  input  logic                reset,
  csr_mem_if.slave            bus,
  output logic [DataSize-1:0] msip,
  output logic [63:0]         mtime,
  output logic [63:0]         mtimecmp
);

  localparam int                  CntSize   = tick_cnt_width(ClockCycles);
  localparam logic [CntSize-1:0]  TickValue = CntSize'(ClockCycles - 1);

  logic [CntSize-1:0] tick_count;
  logic               tick;
  logic [63:0]        wr_data64;
  logic               wr_mtime;
  logic               wr_mtimecmp;
  logic               wr_msip;
  logic [63:0]        mtime_next;
  logic [63:0]        mtimecmp_next;
  logic [63:0]        rd_data64;

  // Prescaler: reloads to 0 on the tick cycle, so it spans 0..ClockCycles-1.
  sync_parallel_counter #(
    .size       (CntSize),
    .init_value ('0)
  ) u_tick_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (tick),
    .load_value ('0),
    .inc_enable (1'b1),
    .dec_enable (1'b0),
    .value      (tick_count)
  );

  assign tick      = (tick_count == TickValue);
  assign wr_data64 = 64'(bus.wr_data);

  assign wr_msip     = bus.wr_en && (bus.addr[1:0] == ADDR_MSIP);
  assign wr_mtime    = bus.wr_en && (bus.addr[1:0] == ADDR_MTIME);
  assign wr_mtimecmp = bus.wr_en && (bus.addr[1:0] == ADDR_MTIMECMP);

  // The tick increment is applied after merging a write, so a write on a
  // tick edge lands as written+1 and the carry crosses the 32-bit halves.
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    if (wr_mtime)
      mtime_next = merge_word(mtime, wr_data64, bus.addr[2], DataSize);
    if (wr_mtimecmp)
      mtimecmp_next = merge_word(mtimecmp, wr_data64, bus.addr[2], DataSize);
    mtime_next = mtime_next + 64'(tick);
  end

  // Register update; reset overrides both writes and timer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      msip     <= '0;
      mtime    <= '0;
      mtimecmp <= '0;
    end else begin
      if (wr_msip)
        msip <= bus.wr_data;
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
    end
  end

  // Read mux; independent of rd_en so data stays valid after rd_en drops.
  always_comb begin
    rd_data64 = '0;
    case (bus.addr[1:0])
      ADDR_MSIP:     rd_data64 = 64'(msip);
      ADDR_RSVD:     rd_data64 = '0;
      ADDR_MTIME:    rd_data64 = select_word(mtime, bus.addr[2], DataSize);
      ADDR_MTIMECMP: rd_data64 = select_word(mtimecmp, bus.addr[2], DataSize);
      default:       rd_data64 = '0;
    endcase
  end

  assign bus.rd_data = rd_data64[DataSize-1:0];
  assign bus.busy    = 1'b0;

endmodule

// File: tb/tb_csr_mem.sv
// -----------------------------------------------------------------------------
// tb_csr_mem
// Self-checking bench for csr_mem (ClockCycles=100, DataSize=32): directed
// table vectors, hand-written timer sequences, and a seeded random run
// compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_csr_mem;

  localparam int CC = 100;
  localparam int DW = 32;

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_msip;
    logic [63:0] exp_cmp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] msip;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model state for the random run.
  logic [31:0] m_msip;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  int          m_cnt;

  vec_t vecs[16];

  csr_mem_if #(.DataSize(DW)) bus ();

  csr_mem #(
    .ClockCycles (CC),
    .DataSize    (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .msip     (msip),
    .mtime    (mtime),
    .mtimecmp (mtimecmp)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                               input logic [2:0] addr, input logic [31:0] wd);
    reset       = rst;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.addr    = addr;
    bus.wr_data = wd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a[1:0])
      2'b00:   return m_msip;
      2'b10:   return a[2] ? m_mtime[63:32] : m_mtime[31:0];
      2'b11:   return a[2] ? m_cmp[63:32] : m_cmp[31:0];
      default: return 32'h0;
    endcase
  endfunction

  // One model step for the inputs currently driven, as of the next edge.
  task automatic modelStep(input logic rst, input logic wr, input logic [2:0] a,
                           input logic [31:0] wd);
    logic        tk;
    logic [63:0] written;
    tk = (m_cnt == CC - 1);
    if (rst) begin
      m_msip  = '0;
      m_mtime = '0;
      m_cmp   = '0;
      m_cnt   = 0;
    end else begin
      written = m_mtime;
      if (wr) begin
        case (a[1:0])
          2'b00: m_msip = wd;
          2'b10: if (a[2]) written[63:32] = wd; else written[31:0] = wd;
          2'b11: if (a[2]) m_cmp[63:32] = wd; else m_cmp[31:0] = wd;
          default: ;
        endcase
      end
      m_mtime = written + (tk ? 64'd1 : 64'd0);
      m_cnt   = tk ? 0 : m_cnt + 1;
    end
  endtask

  initial begin
    vecs[0]  = '{"wr_msip",      1, 0, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 64'h0};
    vecs[1]  = '{"rd_msip",      0, 1, 3'b000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 64'h0};
    vecs[2]  = '{"rd_rsvd",      0, 1, 3'b001, 32'h0,        32'h0,        32'hDEADBEEF, 64'h0};
    vecs[3]  = '{"wr_rsvd",      1, 0, 3'b001, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF, 64'h0};
    vecs[4]  = '{"wr_msip_hi",   1, 0, 3'b100, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 64'h0};
    vecs[5]  = '{"wr_cmp_hi",    1, 0, 3'b111, 32'h12345678, 32'h12345678, 32'h0BADF00D, 64'h12345678_00000000};
    vecs[6]  = '{"wr_cmp_lo",    1, 0, 3'b011, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h0BADF00D, 64'h12345678_9ABCDEF0};
    vecs[7]  = '{"rd_cmp_hi",    0, 1, 3'b111, 32'h0,        32'h12345678, 32'h0BADF00D, 64'h12345678_9ABCDEF0};
    vecs[8]  = '{"rd_cmp_lo",    0, 1, 3'b011, 32'h0,        32'h9ABCDEF0, 32'h0BADF00D, 64'h12345678_9ABCDEF0};
    vecs[9]  = '{"wr_rd_msip",   1, 1, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[10] = '{"rd_rsvd_hi",   0, 1, 3'b101, 32'h0,        32'h0,        32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[11] = '{"rd_noen_cmp",  0, 0, 3'b111, 32'h0,        32'h12345678, 32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[12] = '{"rd_mtime_lo",  0, 1, 3'b010, 32'h0,        32'h0,        32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[13] = '{"rd_mtime_hi",  0, 1, 3'b110, 32'h0,        32'h0,        32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[14] = '{"wr_rsvd_hi",   1, 0, 3'b101, 32'hAAAAAAAA, 32'h0,        32'hDEADBEEF, 64'h12345678_9ABCDEF0};
    vecs[15] = '{"rd_msip_hi",   0, 1, 3'b100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 64'h12345678_9ABCDEF0};

    // Reset state and mtime reads before the first tick.
    applyStimulus(1, 0, 0, 3'b000, 32'h0);
    nextEdge();
    nextEdge();
    applyStimulus(0, 0, 1, 3'b010, 32'h0);
    #1;
    checkOutput("reset_rd_010", 64'(bus.rd_data), 64'h0);
    checkOutput("reset_busy", 64'(bus.busy), 64'h0);
    checkOutput("reset_msip", 64'(msip), 64'h0);
    checkOutput("reset_mtime", mtime, 64'h0);
    checkOutput("reset_mtimecmp", mtimecmp, 64'h0);
    applyStimulus(0, 0, 1, 3'b011, 32'h0);
    #1;
    checkOutput("reset_rd_011", 64'(bus.rd_data), 64'h0);

    // Table-driven single-cycle accesses (well before the first tick).
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      nextEdge();
      applyStimulus(0, 0, 0, vecs[i].addr, 32'h0);
      #1;
      checkOutput({vecs[i].name, "_rd"}, 64'(bus.rd_data), 64'(vecs[i].exp_rd));
      checkOutput({vecs[i].name, "_msip"}, 64'(msip), 64'(vecs[i].exp_msip));
      checkOutput({vecs[i].name, "_cmp"}, mtimecmp, vecs[i].exp_cmp);
      checkOutput({vecs[i].name, "_busy"}, 64'(bus.busy), 64'h0);
    end

    // Idle after reset: increments land exactly on edges 100 and 200.
    applyStimulus(1, 0, 0, 3'b010, 32'h0);
    nextEdge();
    applyStimulus(0, 0, 0, 3'b010, 32'h0);
    for (int e = 1; e <= 250; e++) begin
      nextEdge();
      if (e == 99)  checkOutput("idle_e99", mtime, 64'd0);
      if (e == 100) checkOutput("idle_e100", mtime, 64'd1);
      if (e == 100) checkOutput("idle_e100_rd", 64'(bus.rd_data), 64'd1);
      if (e == 199) checkOutput("idle_e199", mtime, 64'd1);
      if (e == 200) checkOutput("idle_e200", mtime, 64'd2);
      if (e == 250) checkOutput("idle_e250", mtime, 64'd2);
      if (e == 250) checkOutput("idle_busy", 64'(bus.busy), 64'h0);
    end

    // Write on a tick edge: low half write plus tick carries into high half.
    applyStimulus(1, 0, 0, 3'b010, 32'h0);
    nextEdge();
    for (int e = 1; e <= 100; e++) begin
      if (e == 1 || e == 100)
        applyStimulus(0, 1, 0, 3'b010, 32'hFFFFFFFF);
      else
        applyStimulus(0, 0, 0, 3'b010, 32'h0);
      nextEdge();
      if (e == 1)  checkOutput("carry_setup", mtime, 64'h00000000_FFFFFFFF);
      if (e == 99) checkOutput("carry_pre", mtime, 64'h00000000_FFFFFFFF);
    end
    applyStimulus(0, 0, 0, 3'b010, 32'h0);
    #1;
    checkOutput("carry_mtime", mtime, 64'h00000001_00000000);
    checkOutput("carry_rd_lo", 64'(bus.rd_data), 64'h0);
    applyStimulus(0, 0, 0, 3'b110, 32'h0);
    #1;
    checkOutput("carry_rd_hi", 64'(bus.rd_data), 64'h1);

    // Seeded random traffic against the reference model.
    void'($urandom(69420));
    applyStimulus(1, 0, 0, 3'b000, 32'h0);
    modelStep(1, 0, 3'b000, 32'h0);
    nextEdge();
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_wr;
      logic        r_rd;
      logic [2:0]  r_addr;
      logic [31:0] r_wd;
      r_rst  = ($urandom_range(0, 299) == 0);
      r_wr   = 1'($urandom_range(0, 1));
      r_rd   = 1'($urandom_range(0, 1));
      r_addr = 3'($urandom_range(0, 7));
      r_wd   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      applyStimulus(r_rst, r_wr, r_rd, r_addr, r_wd);
      #1;
      checkOutput("rand_rd", 64'(bus.rd_data), 64'(modelRead(r_addr)));
      modelStep(r_rst, r_wr, r_addr, r_wd);
      nextEdge();
      checkOutput("rand_msip", 64'(msip), 64'(m_msip));
      checkOutput("rand_mtime", mtime, m_mtime);
      checkOutput("rand_mtimecmp", mtimecmp, m_cmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/csr_mem.md
CSR_MEM -- requirements
Module: csr_mem

Interface
REQ-001 Parameter ClockCycles, default 100: number of clock cycles per mtime increment; legal range 1..2^16.
REQ-002 Parameter DataSize, default 32 (64 when RV64I is defined): bus width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clock  in  1: sole clock; all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 rd_en  in  1: read request.
REQ-007 wr_en  in  1: write request.
REQ-008 addr  in  3: register select.
REQ-009 wr_data  in  DataSize: write data.
REQ-010 rd_data  out  DataSize: read data.
REQ-011 busy  out  1: access stall indication.
REQ-012 msip  out  DataSize: software interrupt register, direct.
REQ-013 mtime  out  64: timer value, direct.
REQ-014 mtimecmp  out  64: timer compare value, direct.

Function
REQ-015 Address map on addr[1:0]:
- 00: msip (full DataSize bits).
- 01: reserved; reads 0, writes ignored.
- 10: mtime.
- 11: mtimecmp.
REQ-016 DataSize=64: addr[2] is ignored; mtime/mtimecmp are accessed as whole 64-bit words.
REQ-017 DataSize=32 for mtime/mtimecmp: addr[2]=0 selects bits [31:0]; addr[2]=1 selects bits [63:32]. For msip, addr[2] is ignored.
REQ-018 rd_data is a combinational mux of addr over the current register values.
- Valid regardless of rd_en, including the cycle after rd_en falls.
- Reserved address returns all zeros.
REQ-019 Write with wr_en=1 updates the selected register (or half) at the rising edge.
- The new value is visible on the outputs and rd_data immediately after that edge.
- The unselected half is unchanged.
REQ-020 busy is constantly 0; every access completes in one cycle.
REQ-021 Tick generation:
- A free-running counter counts 0..ClockCycles-1, then wraps to 0.
- tick = (count == ClockCycles-1).
REQ-022 On every rising edge with tick=1, mtime increments by 1 (64-bit, wraps from all-ones to 0).
REQ-023 Simultaneous write to mtime and tick:
- mtime := (written 64-bit value) + 1.
- DataSize=32: written value = {new half, other old half}; the +1 carries across halves.
REQ-024 rd_en and wr_en both high: the write executes; rd_data still follows REQ-018.
REQ-025 mtimecmp and msip are never modified by hardware; only writes change them.

Reset
REQ-026 While reset=1 at a rising edge:
- msip, mtime and mtimecmp clear to 0.
- The tick counter clears to 0.
- Writes are ignored.
REQ-027 With reset released, the first mtime increment occurs at the ClockCycles-th rising edge after reset deasserts.

Structure
REQ-028 Sub-module sync_parallel_counter implements the tick counter.
- Parameters: size, init_value.
- Ports: clock, reset, load, load_value, inc_enable, dec_enable, value.
- Instance: size 7 for the default configuration (ceil(log2(ClockCycles)) in general), load = tick, load_value = 0, inc_enable = 1, dec_enable = 0.
REQ-029 Address codes (MSIP=2'b00, RSVD=2'b01, MTIME=2'b10, MTIMECMP=2'b11) belong in the shared package/macros header, alongside the RV64I/DataSize selection.

Verification
REQ-030 Reset, then read addr 3'b010 and 3'b011 before the first tick -> rd_data = 0; busy = 0 throughout.
REQ-031 Write msip = 0xDEADBEEF (addr 3'b000), then read -> msip = rd_data = 0xDEADBEEF; addr 3'b001 reads 0 and a write to it changes nothing.
REQ-032 DataSize=32, mtime = 0x00000000_FFFFFFFF: write 0xFFFFFFFF to addr 3'b010 on a tick edge -> mtime = 0x00000001_00000000.
REQ-033 DataSize=32: write 0x12345678 to 3'b111, then 0x9ABCDEF0 to 3'b011 -> mtimecmp = 0x12345678_9ABCDEF0, and readback of each half matches.
REQ-034 Idle 250 cycles after reset with ClockCycles=100 -> mtime = 2; increments occur exactly at edges 100 and 200.
REQ-035 3000 random reads/writes with seed 69420 -> every readback and every direct output matches the reference model of REQ-015..REQ-023.
